// File: rtl/enc8to3_scan.sv
// Sequential 8-to-3 priority encoder: captures a request vector and emits one index per handshake.
// Optional one-hot violation flag enabled by defining ENC_ONEHOT_CHECK_EN.
module enc8to3_scan #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] Din,
    input  logic       out_ready,
    output logic [2:0] Y,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       none,
    output logic [3:0] count,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] pending_nxt;
    logic [2:0] y_q, y_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       none_q, none_d;
    logic [3:0] count_q, count_d;
    logic       accept;

    // Last set bit in scan order wins, so the loop direction selects the priority end.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // busy_q stays high through the done cycle, which blocks a load until the cycle after done.
    assign accept      = en && load && !busy_q;
    assign pending_nxt = pending_q & ~(8'd1 << y_q);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        none_d      = none_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    pending_d = Din;
                    count_d   = 4'd0;
                    busy_d    = 1'b1;
                    if (Din != 8'h00) begin
                        state_d     = SCAN;
                        y_d         = prio_idx(Din);
                        out_valid_d = 1'b1;
                        none_d      = 1'b0;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        none_d      = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_valid_q && out_ready) begin
                    pending_d = pending_nxt;
                    count_d   = count_q + 4'd1;
                    if (pending_nxt != 8'h00) begin
                        y_d = prio_idx(pending_nxt);
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 8'h00;
            y_q         <= 3'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            none_q      <= 1'b0;
            count_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            none_q      <= none_d;
            count_q     <= count_d;
        end
    end

`ifdef ENC_ONEHOT_CHECK_EN
    logic err_q, err_d;

    // Clearing the lowest set bit leaves something only when more than one bit was set.
    always_comb begin
        err_d = err_q;
        if (accept) err_d = ((Din & (Din - 8'd1)) != 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign none      = none_q;
    assign count     = count_q;

endmodule

// File: tb/tb_enc8to3_scan.sv
// Directed bench for enc8to3_scan; runs both priority orders side by side on shared stimulus.
module tb_enc8to3_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;
    logic       out_ready = 1'b0;

    logic [2:0] y1, y0;
    logic       ov1, ov0, busy1, busy0, done1, done0, none1, none0, err1, err0;
    logic [3:0] cnt1, cnt0;
    logic [10:0] st1, st0;

    int n_checks = 0;
    int n_fail = 0;

`ifdef ENC_ONEHOT_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    enc8to3_scan #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .Din(din), .out_ready(out_ready),
        .Y(y1), .out_valid(ov1), .busy(busy1), .done(done1), .none(none1), .count(cnt1), .err(err1)
    );

    enc8to3_scan #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .Din(din), .out_ready(out_ready),
        .Y(y0), .out_valid(ov0), .busy(busy0), .done(done0), .none(none0), .count(cnt0), .err(err0)
    );

    always #5 clk = ~clk;

    assign st1 = {y1, ov1, busy1, done1, none1, cnt1};
    assign st0 = {y0, ov0, busy0, done0, none0, cnt0};

    function automatic logic [10:0] exp_st(input logic [2:0] y, input logic v, input logic b,
                                           input logic d, input logic n, input logic [3:0] c);
        return {y, v, b, d, n, c};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] d);
        en = 1'b1; load = 1'b1; din = d;
        tick();
        load = 1'b0;
    endtask

    task automatic drain;
        bit ok;
        ok = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy1 && !busy0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin $display("FAIL drain_timeout busy_hi=%0b busy_lo=%0b want 0", busy1, busy0); n_fail++; end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++; if (st1 !== 11'd0) begin $display("FAIL reset_hi got %h want 000", st1); n_fail++; end
        n_checks++; if (st0 !== 11'd0) begin $display("FAIL reset_lo got %h want 000", st0); n_fail++; end
        n_checks++; if ({err1, err0} !== 2'b00) begin $display("FAIL reset_err got %b want 00", {err1, err0}); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (st1 !== 11'd0) begin $display("FAIL idle_after_reset got %h want 000", st1); n_fail++; end
    endtask

    task automatic test_reset_mid_scan;
        logic [10:0] e;
        out_ready = 1'b0;
        ld(8'hF0);
        e = exp_st(3'd7, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e) begin $display("FAIL mid_load_hi got %h want %h", st1, e); n_fail++; end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        e = exp_st(3'd5, 1, 1, 0, 0, 4'd1);
        n_checks++; if (st0 !== e) begin $display("FAIL mid_xfer_lo got %h want %h", st0, e); n_fail++; end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (st1 !== 11'd0 || st0 !== 11'd0) begin $display("FAIL async_reset got %h/%h want 000/000", st1, st0); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++; if (st1 !== 11'd0) begin $display("FAIL post_reset_idle got %h want 000", st1); n_fail++; end
        ld(8'h01);
        e = exp_st(3'd0, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e || st0 !== e) begin $display("FAIL post_reset_load got %h/%h want %h", st1, st0, e); n_fail++; end
        drain();
    endtask

    task automatic test_priority;
        int hi[3] = '{7, 5, 2};
        int lo[3] = '{2, 5, 7};
        logic [10:0] e;
        out_ready = 1'b1;
        ld(8'b1010_0100);
        for (int i = 0; i < 3; i++) begin
            e = exp_st(3'(hi[i]), 1, 1, 0, 0, 4'(i));
            n_checks++; if (st1 !== e) begin $display("FAIL prio_hi_%0d got %h want %h", i, st1, e); n_fail++; end
            e = exp_st(3'(lo[i]), 1, 1, 0, 0, 4'(i));
            n_checks++; if (st0 !== e) begin $display("FAIL prio_lo_%0d got %h want %h", i, st0, e); n_fail++; end
            tick();
        end
        e = exp_st(3'd2, 0, 1, 0, 0, 4'd3);
        n_checks++; if (st1 !== e) begin $display("FAIL prio_end got %h want %h", st1, e); n_fail++; end
        tick();
        e = exp_st(3'd2, 0, 1, 1, 0, 4'd3);
        n_checks++; if (st1 !== e) begin $display("FAIL prio_done got %h want %h", st1, e); n_fail++; end
        e = exp_st(3'd7, 0, 1, 1, 0, 4'd3);
        n_checks++; if (st0 !== e) begin $display("FAIL prio_done_lo got %h want %h", st0, e); n_fail++; end
        tick();
        e = exp_st(3'd2, 0, 0, 0, 0, 4'd3);
        n_checks++; if (st1 !== e) begin $display("FAIL prio_idle got %h want %h", st1, e); n_fail++; end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [10:0] e;
        out_ready = 1'b0;
        ld(8'h81);
        for (int i = 0; i < 4; i++) begin
            e = exp_st(3'd7, 1, 1, 0, 0, 4'd0);
            n_checks++; if (st1 !== e) begin $display("FAIL bp_hold_hi_%0d got %h want %h", i, st1, e); n_fail++; end
            e = exp_st(3'd0, 1, 1, 0, 0, 4'd0);
            n_checks++; if (st0 !== e) begin $display("FAIL bp_hold_lo_%0d got %h want %h", i, st0, e); n_fail++; end
            tick();
        end
        out_ready = 1'b1;
        tick();
        e = exp_st(3'd0, 1, 1, 0, 0, 4'd1);
        n_checks++; if (st1 !== e) begin $display("FAIL bp_second got %h want %h", st1, e); n_fail++; end
        tick();
        e = exp_st(3'd0, 0, 1, 0, 0, 4'd2);
        n_checks++; if (st1 !== e) begin $display("FAIL bp_end got %h want %h", st1, e); n_fail++; end
        tick();
        e = exp_st(3'd0, 0, 1, 1, 0, 4'd2);
        n_checks++; if (st1 !== e) begin $display("FAIL bp_done got %h want %h", st1, e); n_fail++; end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_zero_and_gating;
        logic [10:0] e;
        out_ready = 1'b1;
        ld(8'h00);
        e = exp_st(3'd0, 0, 1, 0, 1, 4'd0);
        n_checks++; if (st1[7:0] !== e[7:0]) begin $display("FAIL zero_load got %h want %h", st1[7:0], e[7:0]); n_fail++; end
        tick();
        e = exp_st(3'd0, 0, 1, 1, 1, 4'd0);
        n_checks++; if (st0[7:0] !== e[7:0]) begin $display("FAIL zero_done got %h want %h", st0[7:0], e[7:0]); n_fail++; end
        tick();
        e = exp_st(3'd0, 0, 0, 0, 1, 4'd0);
        n_checks++; if (st1[7:0] !== e[7:0]) begin $display("FAIL zero_idle got %h want %h", st1[7:0], e[7:0]); n_fail++; end
        en = 1'b0; load = 1'b1; din = 8'h10;
        tick();
        tick();
        load = 1'b0; en = 1'b1;
        n_checks++; if (st1[7:0] !== e[7:0]) begin $display("FAIL en_gate got %h want %h", st1[7:0], e[7:0]); n_fail++; end
        out_ready = 1'b0;
        ld(8'h81);
        load = 1'b1; din = 8'h01;
        tick();
        load = 1'b0;
        e = exp_st(3'd7, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e) begin $display("FAIL busy_load_hi got %h want %h", st1, e); n_fail++; end
        out_ready = 1'b1;
        tick();
        e = exp_st(3'd7, 1, 1, 0, 0, 4'd1);
        n_checks++; if (st0 !== e) begin $display("FAIL busy_load_lo got %h want %h", st0, e); n_fail++; end
        drain();
        n_checks++; if (cnt1 !== 4'd2) begin $display("FAIL busy_load_count got %0d want 2", cnt1); n_fail++; end
    endtask

    task automatic test_back_to_back;
        logic [10:0] e;
        out_ready = 1'b1;
        ld(8'h02);
        e = exp_st(3'd1, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e || st0 !== e) begin $display("FAIL b2b_first got %h/%h want %h", st1, st0, e); n_fail++; end
        tick();
        tick();
        e = exp_st(3'd1, 0, 1, 1, 0, 4'd1);
        n_checks++; if (st1 !== e) begin $display("FAIL b2b_done got %h want %h", st1, e); n_fail++; end
        en = 1'b1; load = 1'b1; din = 8'h08;
        tick();
        e = exp_st(3'd1, 0, 0, 0, 0, 4'd1);
        n_checks++; if (st1 !== e) begin $display("FAIL b2b_done_cycle_load got %h want %h", st1, e); n_fail++; end
        tick();
        load = 1'b0;
        e = exp_st(3'd3, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e) begin $display("FAIL b2b_reload got %h want %h", st1, e); n_fail++; end
        drain();
    endtask

    task automatic test_full;
        logic [10:0] e;
        out_ready = 1'b1;
        ld(8'hFF);
        for (int i = 0; i < 8; i++) begin
            e = exp_st(3'(7 - i), 1, 1, 0, 0, 4'(i));
            n_checks++; if (st1 !== e) begin $display("FAIL full_hi_%0d got %h want %h", i, st1, e); n_fail++; end
            e = exp_st(3'(i), 1, 1, 0, 0, 4'(i));
            n_checks++; if (st0 !== e) begin $display("FAIL full_lo_%0d got %h want %h", i, st0, e); n_fail++; end
            tick();
        end
        e = exp_st(3'd0, 0, 1, 0, 0, 4'd8);
        n_checks++; if (st1 !== e) begin $display("FAIL full_end got %h want %h", st1, e); n_fail++; end
        drain();
        n_checks++; if (cnt1 !== 4'd8 || cnt0 !== 4'd8) begin $display("FAIL full_count_hold got %0d/%0d want 8", cnt1, cnt0); n_fail++; end
    endtask

    task automatic test_onehot;
        logic [10:0] e;
        out_ready = 1'b0;
        ld(8'h10);
        e = exp_st(3'd4, 1, 1, 0, 0, 4'd0);
        n_checks++; if (st1 !== e || st0 !== e) begin $display("FAIL onehot_y got %h/%h want %h", st1, st0, e); n_fail++; end
        n_checks++; if ({err1, err0} !== 2'b00) begin $display("FAIL onehot_err got %b want 00", {err1, err0}); n_fail++; end
        drain();
        ld(8'h11);
        n_checks++; if (err1 !== ERR_ON || err0 !== ERR_ON) begin $display("FAIL multi_err got %b%b want %b", err1, err0, ERR_ON); n_fail++; end
        n_checks++; if (y1 !== 3'd4 || y0 !== 3'd0) begin $display("FAIL multi_first got %0d/%0d want 4/0", y1, y0); n_fail++; end
        out_ready = 1'b1;
        tick();
        n_checks++; if (y1 !== 3'd0 || y0 !== 3'd4 || !ov1) begin $display("FAIL multi_second got %0d/%0d v=%b want 0/4 v=1", y1, y0, ov1); n_fail++; end
        drain();
        n_checks++; if (err1 !== ERR_ON) begin $display("FAIL multi_err_hold got %b want %b", err1, ERR_ON); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_reset_mid_scan();
        test_priority();
        test_backpressure();
        test_zero_and_gating();
        test_back_to_back();
        test_full();
        test_onehot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
